// File: rtl/top.sv
// RGB colour-wheel PWM driver: three active-low LED channels cross-fade
// through six phases, one ramp step per PWM period.
module top #(
  parameter int PWM_INTERVAL = 1200
) (
  input  logic clk,
  input  logic rst_n,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  // state | meaning
  // PH_0  | R full, G ramps up,   B off
  // PH_1  | R ramps down, G full, B off
  // PH_2  | R off, G full,        B ramps up
  // PH_3  | R off, G ramps down,  B full
  // PH_4  | R ramps up, G off,    B full
  // PH_5  | R full, G off,        B ramps down
  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4,
    PH_5 = 3'd5
  } phase_t;

  localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int DW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] ZERO = '0;

  logic [CW-1:0] pwm_cnt;
  logic [CW-1:0] ramp;
  phase_t        phase;
  phase_t        phase_nxt;

  logic          period_end;
  logic          ramp_end;
  logic [DW-1:0] up;
  logic [DW-1:0] dn;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic [DW-1:0] cnt_ext;

  assign period_end = (pwm_cnt == LAST);
  assign ramp_end   = (ramp == LAST);
  assign up         = {1'b0, ramp};
  assign dn         = FULL - DW'(1) - up;
  assign cnt_ext    = {1'b0, pwm_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      ramp    <= '0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + CW'(1);
      if (period_end) begin
        ramp <= ramp_end ? '0 : ramp + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_0;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    duty_r    = ZERO;
    duty_g    = ZERO;
    duty_b    = ZERO;
    unique case (phase)
      PH_0: begin duty_r = FULL; duty_g = up;   duty_b = ZERO; end
      PH_1: begin duty_r = dn;   duty_g = FULL; duty_b = ZERO; end
      PH_2: begin duty_r = ZERO; duty_g = FULL; duty_b = up;   end
      PH_3: begin duty_r = ZERO; duty_g = dn;   duty_b = FULL; end
      PH_4: begin duty_r = up;   duty_g = ZERO; duty_b = FULL; end
      PH_5: begin duty_r = FULL; duty_g = ZERO; duty_b = dn;   end
      default: ;
    endcase
    // Phase only moves on the last period of a full ramp.
    if (period_end && ramp_end) begin
      unique case (phase)
        PH_0:    phase_nxt = PH_1;
        PH_1:    phase_nxt = PH_2;
        PH_2:    phase_nxt = PH_3;
        PH_3:    phase_nxt = PH_4;
        PH_4:    phase_nxt = PH_5;
        default: phase_nxt = PH_0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGB_R <= 1'b1;
      RGB_G <= 1'b1;
      RGB_B <= 1'b1;
    end else begin
      RGB_R <= !(cnt_ext < duty_r);
      RGB_G <= !(cnt_ext < duty_g);
      RGB_B <= !(cnt_ext < duty_b);
    end
  end

endmodule

// File: tb/tb_top.sv
// Randomized bench for the RGB colour wheel; expected outputs come from a
// time-index model of the wheel at PWM_INTERVAL = 4.
module tb_top;

  localparam int P = 4;

  logic clk;
  logic rst_n;
  logic rgb_r, rgb_g, rgb_b;

  int n_checks = 0;
  int n_errors = 0;
  int t_idx    = 0;

  top #(.PWM_INTERVAL(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RGB_R (rgb_r),
    .RGB_G (rgb_g),
    .RGB_B (rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, t_idx, got, exp);
    end
  endtask

  // Expected {R,G,B} for the t-th clock cycle of the wheel after reset release.
  function automatic logic [2:0] model_rgb(input int t);
    int cnt, rmp, ph;
    int d [3];
    int lvl_up, lvl_dn;
    logic [2:0] res;
    cnt    = t % P;
    rmp    = (t / P) % P;
    ph     = (t / (P * P)) % 6;
    lvl_up = rmp;
    lvl_dn = P - 1 - rmp;
    case (ph)
      0: d = '{P, lvl_up, 0};
      1: d = '{lvl_dn, P, 0};
      2: d = '{0, P, lvl_up};
      3: d = '{0, lvl_dn, P};
      4: d = '{lvl_up, 0, P};
      default: d = '{P, 0, lvl_dn};
    endcase
    for (int c = 0; c < 3; c++) res[2-c] = !(cnt < d[c]);
    return res;
  endfunction

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("wheel", {rgb_r, rgb_g, rgb_b}, model_rgb(t_idx));
      t_idx++;
    end
  endtask

  // Called just after a posedge sample; asserts reset between edges.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {rgb_r, rgb_g, rgb_b}, 3'b111);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check("rst_hold", {rgb_r, rgb_g, rgb_b}, 3'b111);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t_idx = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset", {rgb_r, rgb_g, rgb_b}, 3'b111);
    end
    rst_n = 1'b1;
    t_idx = 0;

    // Full wheel (96 cycles) plus wrap into the next wheel.
    run_cycles(104);

    // Reset mid-wheel, then reset again while in phase 3.
    async_reset(2);
    run_cycles(52);
    async_reset(1);
    run_cycles(8);

    for (int k = 0; k < 6; k++) begin
      run_cycles($urandom_range(10, 130));
      async_reset($urandom_range(0, 3));
      run_cycles(4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0d", t_idx);
    $fatal(1, "timeout");
  end

endmodule
